// File: rtl/conv_window_stream.sv
// Sliding K x K (x CHANNELS) window generator over a row-major pixel stream.
// K-1 line buffers feed the newest window column; windows are only emitted once fully inside the frame.
module conv_window_stream #(
  parameter int BYTE_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int K          = 3,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  localparam int PIX_W      = BYTE_WIDTH * CHANNELS,
  localparam int WIND_WIDTH = PIX_W * K * K
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [PIX_W-1:0]      i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [WIND_WIDTH-1:0] o_window,
  output logic                  o_frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0]      col_reg, col_next;
  logic [ROW_W-1:0]      row_reg, row_next;
  logic                  accept;
  logic                  last_col, last_row;
  logic                  produce;
  logic [PIX_W-1:0]      lb_rd [K-1];
  logic [WIND_WIDTH-1:0] win_next;

  assign o_ready  = ~i_start & (~o_valid | i_ready);
  assign accept   = i_valid & o_ready;
  assign last_col = (col_reg == COL_W'(IMG_W - 1));
  assign last_row = (row_reg == ROW_W'(IMG_H - 1));
  // A window is complete only when K rows and K columns of this frame are behind it.
  assign produce  = (row_reg >= ROW_W'(K - 1)) & (col_reg >= COL_W'(K - 1));

  always_comb begin
    col_next = col_reg + COL_W'(1);
    row_next = row_reg;
    if (last_col) begin
      col_next = '0;
      row_next = last_row ? '0 : row_reg + ROW_W'(1);
    end
  end

  // Line buffer j holds row (current-1-j); on accept each buffer passes its old pixel down.
  for (genvar gi = 0; gi < K - 1; gi++) begin : g_lb
    logic [PIX_W-1:0] lb_mem [IMG_W];

    assign lb_rd[gi] = lb_mem[col_reg];

    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (accept) lb_mem[col_reg] <= i_data;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (accept) lb_mem[col_reg] <= lb_rd[gi-1];
      end
    end
  end

  // Element e = (K-1-r)*K + (K-1-c): shifting left by one column means e takes e-1,
  // except the newest column (e % K == 0) which is loaded from i_data / line buffers.
  for (genvar gi = 0; gi < K * K; gi++) begin : g_win
    if (gi % K != 0) begin : g_shift
      assign win_next[gi*PIX_W +: PIX_W] = o_window[(gi-1)*PIX_W +: PIX_W];
    end else if (gi / K == 0) begin : g_new
      assign win_next[gi*PIX_W +: PIX_W] = i_data;
    end else begin : g_lbcol
      assign win_next[gi*PIX_W +: PIX_W] = lb_rd[gi/K - 1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_window <= '0;
    end else if (accept) begin
      o_window <= win_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg      <= '0;
      row_reg      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (i_start) begin
      col_reg      <= '0;
      row_reg      <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else if (accept) begin
      col_reg      <= col_next;
      row_reg      <= row_next;
      o_valid      <= produce;
      o_frame_done <= last_col & last_row;
    end else begin
      o_frame_done <= 1'b0;
      if (o_valid & i_ready) o_valid <= 1'b0;
    end
  end

endmodule
